// File: rtl/earth_tx_framer_if.sv
// FIFO write bus and MAC byte stream for the TX framer.
// master = producer/MAC side, slave = framer side.
interface earth_tx_framer_if;
    logic [63:0] etx_din;
    logic        ewr_en;
    logic        etx_full;
    logic        etx_empty;
    logic [7:0]  mac_tx_data;
    logic        mac_tx_valid;
    logic        mac_tx_ready;
    logic        mac_tx_sof;
    logic        mac_tx_eof;

    modport master (
        output etx_din, ewr_en, mac_tx_ready,
        input  etx_full, etx_empty, mac_tx_data, mac_tx_valid, mac_tx_sof, mac_tx_eof
    );

    modport slave (
        input  etx_din, ewr_en, mac_tx_ready,
        output etx_full, etx_empty, mac_tx_data, mac_tx_valid, mac_tx_sof, mac_tx_eof
    );
endinterface

// File: rtl/earth_tx_framer.sv
// TX word FIFO plus framer: 4-byte length header then MSB-first payload bytes, IFG between frames.
// First byte 2 cycles after request edge; byte outputs registered and held while mac_tx_ready is low.
module earth_tx_framer #(
    parameter int DEPTH      = 512,
    parameter int IFG_CYCLES = 12
) (
    input  logic             clk,
    input  logic             e_reset_n,
    earth_tx_framer_if.slave bus,
    input  logic             etx_fifo_rst,
    input  logic             etx_enable,
    input  logic [15:0]      tx_data_length,
    input  logic [15:0]      tx_total_length,
    output logic             frame_abort,
    output logic             len_err,
    output logic             ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(IFG_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} state_t;

    logic [63:0]   mem [DEPTH];
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          en_q, en_d, pending_q, pending_d;
    logic [15:0]   tot_q, tot_d, dlen_q, dlen_d, idx_q, idx_d;
    logic [1:0]    hdr_q, hdr_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    dat_q, dat_d;
    logic          vld_q, vld_d, sof_q, sof_d, eof_q, eof_d;
    logic          abort_q, abort_d, lerr_q, lerr_d, ovf_q, ovf_d;
    logic          full, push, pop, req, xfer, last;
    logic [16:0]   words_in, words_q;
    logic [15:0]   nxt_idx;
    logic [63:0]   rd_word, nx_word, sel_word;

    assign full     = (cnt_q == CW'(DEPTH));
    assign push     = bus.ewr_en && !full && !etx_fifo_rst;
    assign req      = etx_enable && !en_q;
    assign xfer     = vld_q && bus.mac_tx_ready;
    assign words_in = ({1'b0, tx_data_length} + 17'd7) >> 3;
    assign words_q  = ({1'b0, dlen_q} + 17'd7) >> 3;
    assign last     = (idx_q == dlen_q - 16'd1);
    assign nxt_idx  = idx_q + 16'd1;
    assign rd_word  = mem[rd_ptr_q];
    assign nx_word  = mem[rd_ptr_q + AW'(1)];

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        en_d      = etx_enable;
        pending_d = pending_q;
        tot_d     = tot_q;
        dlen_d    = dlen_q;
        idx_d     = idx_q;
        hdr_d     = hdr_q;
        gap_d     = gap_q;
        dat_d     = dat_q;
        vld_d     = vld_q;
        sof_d     = sof_q;
        eof_d     = eof_q;
        ovf_d     = ovf_q;
        abort_d   = 1'b0;
        lerr_d    = 1'b0;
        pop       = 1'b0;
        sel_word  = rd_word;

        case (state_q)
            IDLE: begin
                // Frame only starts once every word it needs is already buffered.
                if (pending_q && (32'(cnt_q) >= 32'(words_q))) begin
                    state_d   = HDR;
                    pending_d = 1'b0;
                    vld_d     = 1'b1;
                    sof_d     = 1'b1;
                    eof_d     = 1'b0;
                    dat_d     = tot_q[15:8];
                    hdr_d     = 2'd0;
                end
            end
            HDR: begin
                if (xfer) begin
                    sof_d = 1'b0;
                    hdr_d = hdr_q + 2'd1;
                    case (hdr_q)
                        2'd0: dat_d = tot_q[7:0];
                        2'd1: dat_d = dlen_q[15:8];
                        2'd2: begin
                            dat_d = dlen_q[7:0];
                            eof_d = (dlen_q == 16'd0);
                        end
                        default: begin
                            idx_d = 16'd0;
                            if (dlen_q == 16'd0) begin
                                state_d = GAP;
                                vld_d   = 1'b0;
                                eof_d   = 1'b0;
                                gap_d   = '0;
                            end else begin
                                state_d = DATA;
                                dat_d   = rd_word[63:56];
                                eof_d   = (dlen_q == 16'd1);
                            end
                        end
                    endcase
                end
            end
            DATA: begin
                if (xfer) begin
                    pop = last || (idx_q[2:0] == 3'd7);
                    if (last) begin
                        state_d = GAP;
                        vld_d   = 1'b0;
                        eof_d   = 1'b0;
                        gap_d   = '0;
                    end else begin
                        // Crossing a word boundary: the next byte comes from the word behind the one popping now.
                        sel_word = (idx_q[2:0] == 3'd7) ? nx_word : rd_word;
                        dat_d    = sel_word[{~nxt_idx[2:0], 3'b000} +: 8];
                        idx_d    = nxt_idx;
                        eof_d    = (nxt_idx == dlen_q - 16'd1);
                    end
                end
            end
            GAP: begin
                if (gap_q == GW'(IFG_CYCLES - 1)) state_d = IDLE;
                else                              gap_d   = gap_q + GW'(1);
            end
            default: state_d = IDLE;
        endcase

        // A request landing in GAP is accepted and waits out the gap as pending.
        if (req && !pending_q && (state_q == IDLE || state_q == GAP)) begin
            if (words_in > 17'(DEPTH)) begin
                lerr_d = 1'b1;
            end else begin
                pending_d = 1'b1;
                tot_d     = tx_total_length;
                dlen_d    = tx_data_length;
            end
        end

        if (bus.ewr_en && full) ovf_d = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d    = cnt_q + CW'(push) - CW'(pop);

        if (etx_fifo_rst) begin
            abort_d   = (state_q == HDR) || (state_q == DATA);
            state_d   = IDLE;
            cnt_d     = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            pending_d = 1'b0;
            ovf_d     = 1'b0;
            lerr_d    = 1'b0;
            vld_d     = 1'b0;
            sof_d     = 1'b0;
            eof_d     = 1'b0;
            gap_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.etx_din;
    end

    always_ff @(posedge clk or negedge e_reset_n) begin
        if (!e_reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            en_q      <= 1'b0;
            pending_q <= 1'b0;
            tot_q     <= '0;
            dlen_q    <= '0;
            idx_q     <= '0;
            hdr_q     <= '0;
            gap_q     <= '0;
            dat_q     <= '0;
            vld_q     <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            abort_q   <= 1'b0;
            lerr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            en_q      <= en_d;
            pending_q <= pending_d;
            tot_q     <= tot_d;
            dlen_q    <= dlen_d;
            idx_q     <= idx_d;
            hdr_q     <= hdr_d;
            gap_q     <= gap_d;
            dat_q     <= dat_d;
            vld_q     <= vld_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            abort_q   <= abort_d;
            lerr_q    <= lerr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.etx_full     = full;
    assign bus.etx_empty    = (cnt_q == '0);
    assign bus.mac_tx_data  = dat_q;
    assign bus.mac_tx_valid = vld_q;
    assign bus.mac_tx_sof   = sof_q;
    assign bus.mac_tx_eof   = eof_q;
    assign frame_abort      = abort_q;
    assign len_err          = lerr_q;
    assign ovf              = ovf_q;
endmodule

// File: tb/tb_earth_tx_framer.sv
// Directed bench for earth_tx_framer: expected bytes are queued when a frame is requested
// and a negedge monitor pops and compares every transferred byte.
module tb_earth_tx_framer;
    localparam int DEPTH = 512;
    localparam int IFG   = 12;

    logic        clk = 1'b0;
    logic        e_reset_n;
    logic        etx_fifo_rst = 1'b0;
    logic        etx_enable = 1'b0;
    logic [15:0] tx_data_length = '0;
    logic [15:0] tx_total_length = '0;
    logic        frame_abort, len_err, ovf;
    bit          rdy_toggle = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    typedef struct packed {
        logic [7:0] dat;
        logic       sof;
        logic       eof;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model_q[$];

    earth_tx_framer_if bus_if ();

    earth_tx_framer #(.DEPTH(DEPTH), .IFG_CYCLES(IFG)) dut (
        .clk             (clk),
        .e_reset_n       (e_reset_n),
        .bus             (bus_if),
        .etx_fifo_rst    (etx_fifo_rst),
        .etx_enable      (etx_enable),
        .tx_data_length  (tx_data_length),
        .tx_total_length (tx_total_length),
        .frame_abort     (frame_abort),
        .len_err         (len_err),
        .ovf             (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic exp_push(input logic [7:0] d, input logic s, input logic e);
        exp_t x;
        x.dat = d;
        x.sof = s;
        x.eof = e;
        sb.push_back(x);
    endtask

    task automatic push(input logic [63:0] w);
        bus_if.etx_din = w;
        bus_if.ewr_en  = 1'b1;
        @(posedge clk); #1;
        bus_if.ewr_en  = 1'b0;
        if (model_q.size() < DEPTH) model_q.push_back(w);
    endtask

    task automatic request(input logic [15:0] tot, input logic [15:0] dl);
        int          nw;
        bit          err;
        logic [63:0] w;
        nw  = (int'(dl) + 7) / 8;
        err = (nw > DEPTH);
        if (!err) begin
            exp_push(tot[15:8], 1'b1, 1'b0);
            exp_push(tot[7:0],  1'b0, 1'b0);
            exp_push(dl[15:8],  1'b0, 1'b0);
            exp_push(dl[7:0],   1'b0, dl == 16'd0);
            for (int i = 0; i < int'(dl); i++) begin
                w = model_q[i / 8];
                exp_push(w[(7 - (i % 8)) * 8 +: 8], 1'b0, i == int'(dl) - 1);
            end
            repeat (nw) void'(model_q.pop_front());
        end
        tx_total_length = tot;
        tx_data_length  = dl;
        etx_enable      = 1'b1;
        @(posedge clk); #1;
        etx_enable      = 1'b0;
        chk("len_err", len_err, err);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_done", sb.size(), 0);
    endtask

    task automatic two_words();
        push(64'h0001020304050607);
        push(64'h08090A0B0C0D0E0F);
    endtask

    initial begin
        bus_if.mac_tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus_if.mac_tx_ready = rdy_toggle ? ~bus_if.mac_tx_ready : 1'b1;
        end
    end

    initial begin : monitor
        exp_t       e;
        logic       stalled;
        logic [7:0] s_dat;
        logic       s_sof, s_eof;
        int         last_eof;
        bit         have_eof;
        stalled  = 1'b0;
        have_eof = 1'b0;
        last_eof = 0;
        forever begin
            @(negedge clk);
            if (e_reset_n !== 1'b1) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                chk("stall_valid", bus_if.mac_tx_valid, 1'b1);
                chk("stall_data",  bus_if.mac_tx_data,  s_dat);
                chk("stall_sof",   bus_if.mac_tx_sof,   s_sof);
                chk("stall_eof",   bus_if.mac_tx_eof,   s_eof);
            end
            if (bus_if.mac_tx_valid && bus_if.mac_tx_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected no byte", bus_if.mac_tx_data);
                end else begin
                    e = sb.pop_front();
                    chk("byte_data", bus_if.mac_tx_data, e.dat);
                    chk("byte_sof",  bus_if.mac_tx_sof,  e.sof);
                    chk("byte_eof",  bus_if.mac_tx_eof,  e.eof);
                    if (bus_if.mac_tx_sof && have_eof)
                        chk("ifg_min_gap", (cyc - last_eof) > IFG, 1'b1);
                    if (bus_if.mac_tx_eof) begin
                        have_eof = 1'b1;
                        last_eof = cyc;
                    end
                end
            end
            stalled = bus_if.mac_tx_valid && !bus_if.mac_tx_ready;
            s_dat   = bus_if.mac_tx_data;
            s_sof   = bus_if.mac_tx_sof;
            s_eof   = bus_if.mac_tx_eof;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit found;
        bus_if.ewr_en  = 1'b0;
        bus_if.etx_din = '0;
        e_reset_n      = 1'b1;
        #1 e_reset_n   = 1'b0;
        #1;
        chk("rst_data",   bus_if.mac_tx_data,  8'h00);
        chk("rst_valid",  bus_if.mac_tx_valid, 1'b0);
        chk("rst_sof",    bus_if.mac_tx_sof,   1'b0);
        chk("rst_eof",    bus_if.mac_tx_eof,   1'b0);
        chk("rst_abort",  frame_abort,         1'b0);
        chk("rst_len_err", len_err,            1'b0);
        chk("rst_ovf",    ovf,                 1'b0);
        chk("rst_empty",  bus_if.etx_empty,    1'b1);
        chk("rst_full",   bus_if.etx_full,     1'b0);
        repeat (3) @(posedge clk);
        #1 e_reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic 16-byte frame
        two_words();
        chk("empty_after_push", bus_if.etx_empty, 1'b0);
        request(16'h0030, 16'd16);
        drain(200);
        chk("basic_empty", bus_if.etx_empty, 1'b1);

        // Partial final word, requested during the inter-frame gap
        two_words();
        request(16'h001B, 16'd11);
        drain(200);
        chk("partial_empty", bus_if.etx_empty, 1'b1);

        // Backpressure
        rdy_toggle = 1'b1;
        two_words();
        request(16'h0030, 16'd16);
        drain(400);
        rdy_toggle = 1'b0;
        chk("bp_empty", bus_if.etx_empty, 1'b1);

        // Oversize request is rejected; monitor flags any stray byte
        request(16'h0000, 16'(DEPTH * 8 + 1));
        repeat (30) @(posedge clk);
        #1;

        // Zero-length frame: header only
        request(16'h0004, 16'd0);
        drain(100);

        // Fill to full, one overflowing push, then a full-depth frame
        for (int i = 0; i < DEPTH; i++) push({32'hC0DE0000 + 32'(i), 32'(i) ^ 32'h5A5A5A5A});
        chk("full_after_depth", bus_if.etx_full, 1'b1);
        chk("ovf_before_extra", ovf, 1'b0);
        push(64'hDEADBEEFDEADBEEF);
        chk("ovf_after_extra", ovf, 1'b1);
        chk("full_after_extra", bus_if.etx_full, 1'b1);
        request(16'(DEPTH * 8 + 4), 16'(DEPTH * 8));
        drain(DEPTH * 8 + 100);
        chk("big_empty", bus_if.etx_empty, 1'b1);
        chk("ovf_sticky", ovf, 1'b1);

        // Flush while payload byte 5 is on the bus
        repeat (IFG + 2) @(posedge clk);
        #1;
        two_words();
        request(16'h0030, 16'd16);
        n = 0;
        found = 1'b0;
        while (!found && n < 100) begin
            @(negedge clk);
            if (bus_if.mac_tx_valid && bus_if.mac_tx_data == 8'h05) found = 1'b1;
            n++;
        end
        chk("flush_byte5_seen", found, 1'b1);
        etx_fifo_rst = 1'b1;
        @(posedge clk); #1;
        chk("flush_left_bytes", sb.size(), 10);
        sb.delete();
        model_q.delete();
        chk("flush_abort",  frame_abort,         1'b1);
        chk("flush_valid",  bus_if.mac_tx_valid, 1'b0);
        chk("flush_empty",  bus_if.etx_empty,    1'b1);
        chk("flush_ovf",    ovf,                 1'b0);
        etx_fifo_rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_one_cycle", frame_abort, 1'b0);

        // Frame after flush
        two_words();
        request(16'h0030, 16'd16);
        drain(200);
        chk("post_flush_empty", bus_if.etx_empty, 1'b1);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/earth_tx_framer.md
# earth_tx_framer

Ethernet TX framing stage directly downstream of the command controller's TX mux: it owns the TX word FIFO behind `etx_din`/`ewr_en`/`etx_full`/`etx_empty`, and converts each requested frame into a byte stream for the MAC. The active mode's `etx_enable`, `tx_data_length` and `tx_total_length` define each frame. Output is a valid/ready byte interface with start/end markers and a 4-byte length header.

## Interface
- `DEPTH`, 512: FIFO depth in 64-bit words; power of two, ≥ 4.
- `IFG_CYCLES`, 12: idle cycles enforced between frames; ≥ 1.
- `clk`  in  1  system clock; all logic on rising edge.
- `e_reset_n`  in  1  asynchronous, active-low reset.
- `etx_din`  in  64  TX data word.
- `ewr_en`  in  1  push `etx_din` when high and FIFO not full.
- `etx_fifo_rst`  in  1  synchronous flush, active high.
- `etx_enable`  in  1  frame request; rising edge is the request.
- `tx_data_length`  in  16  payload bytes of the requested frame.
- `tx_total_length`  in  16  total-length field, carried in the header only.
- `etx_full`  out  1  FIFO count == DEPTH.
- `etx_empty`  out  1  FIFO count == 0.
- `mac_tx_data`  out  8  output byte.
- `mac_tx_valid`  out  1  byte valid.
- `mac_tx_ready`  in  1  MAC accepts the byte.
- `mac_tx_sof`  out  1  first header byte, qualified by valid.
- `mac_tx_eof`  out  1  last byte of frame, qualified by valid.
- `frame_abort`  out  1  one-cycle pulse when a flush kills an in-flight frame.
- `len_err`  out  1  one-cycle pulse when a request is rejected.
- `ovf`  out  1  sticky: a write was attempted while full. Cleared by flush or reset.

## Operation
- FIFO: count register width log2(DEPTH)+1. `etx_full` and `etx_empty` decode the registered count. A push while full is dropped and sets `ovf`. A push and a pop in the same cycle leave count unchanged.
- Request: a 0→1 edge of `etx_enable` sets `pending` and latches both lengths. A further edge while pending or mid-frame is ignored.
- Word count: words = ceil(tx_data_length/8) = (len+7)>>3, computed in 17 bits.
  - If words > DEPTH, `len_err` pulses and the request is discarded.
- States: IDLE, HDR, DATA, GAP.
- IDLE → HDR when `pending` and FIFO count ≥ words. `pending` clears on the transition.
- HDR: emits 4 bytes in this order: total[15:8], total[7:0], data[15:8], data[7:0].
  - `mac_tx_sof` is high on the first byte.
  - If data length is 0, the 4th byte carries `mac_tx_eof`, then the state goes to GAP.
- DATA: emits payload bytes from each word, MSB byte first (bits 63:56 first).
  - The word pops when its 8th byte transfers, or when the frame's last byte transfers.
  - Unused bytes of a partial final word are discarded.
  - The last payload byte carries `mac_tx_eof`, then the state goes to GAP.
- GAP: holds for IFG_CYCLES cycles with `mac_tx_valid`=0, then returns to IDLE.
- Handshake: a byte transfers when valid && ready. While valid && !ready, `mac_tx_data`, `mac_tx_sof` and `mac_tx_eof` hold stable. Valid never drops mid-frame except on flush.
- Flush (`etx_fifo_rst`), takes priority over everything:
  - Count is zeroed and pointers reset; `pending` and `ovf` clear.
  - The state goes to IDLE, skipping GAP.
  - If the state was HDR or DATA, `frame_abort` pulses for 1 cycle.
  - Pushes in the flush cycle are dropped.

## Timing
- Reset values:
  - Outputs: `mac_tx_data`=0, `mac_tx_valid`=0, `mac_tx_sof`=0, `mac_tx_eof`=0, `frame_abort`=0, `len_err`=0, `ovf`=0, `etx_empty`=1, `etx_full`=0.
  - Internal: state IDLE, count 0.
- Push to count-visible latency: 1 cycle.
- Request latency:
  - The edge is detected in the cycle after `etx_enable` goes high.
  - If data is already present, HDR (first valid byte) starts 2 cycles after `etx_enable` rises.
  - `len_err` asserts 1 cycle after the edge.
- Throughput: 1 byte/cycle when ready is held high. Frame occupancy = 4 + len cycles, plus IFG_CYCLES.
- Reset asserted mid-frame: all outputs take reset values immediately. No `frame_abort` pulse.

## Test plan
- Basic frame: push words 0x0001020304050607 and 0x08090A0B0C0D0E0F; total=0x0030, data=16; pulse `etx_enable`.
  - Bytes out: 00 30 00 10 then 00..0F.
  - sof on byte 0, eof on byte 19, FIFO empty after, 12 idle cycles before the next frame.
- Partial word: data=11, 2 words pushed.
  - 4 header bytes + 11 payload bytes, ending 0x0A with eof.
  - Both words popped, `etx_empty`=1.
- Backpressure: same as basic frame, with `mac_tx_ready` toggling every cycle.
  - Identical byte sequence; data held stable while stalled; no loss or duplicates.
- Zero/oversize length:
  - data=0 → 4-byte frame, eof on byte 3.
  - data=DEPTH*8+1 → `len_err` pulse, no output, state stays IDLE.
- Full/overflow: push DEPTH+1 words.
  - `etx_full`=1 after DEPTH pushes; `ovf`=1.
  - A subsequent DEPTH*8-byte frame outputs exactly the first DEPTH words.
- Flush mid-frame: assert `etx_fifo_rst` during payload byte 5.
  - `frame_abort` pulses once, valid drops the next cycle, count=0, next request is framed correctly.
